wash_sequencer: RTL

Program sequencer for the washing-machine controller. It owns the power state and the wash-program phase FSM, and counts program time on a 1 Hz tick. It drives the seven-segment display driver's inputs `power_light`, `current_time`, `total_time`, `current_water` and `rest_time`. All outputs are registered decimal-range binary values (0–99) ready for digit splitting.

---
 rtl/wash_sequencer_pkg.sv | 72 +++++++
 rtl/wash_sequencer_if.sv | 37 +++
 rtl/wash_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wash_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wash_pkg                                                      |
// | Purpose  : Shared types, phase encodings, default durations and helper   |
// |            functions for the washing-machine program sequencer.          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package wash_pkg;

    typedef logic [6:0] time_t;   // 0..99 display-ready seconds
    typedef logic [2:0] water_t;  // water level 0..7
    typedef logic [2:0] phase_t;  // externally visible phase code

    // Default program parameters
    localparam int DEF_WATER_LVL = 5;
    localparam int DEF_FILL_STEP = 2;
    localparam int DEF_WASH_T    = 20;
    localparam int DEF_RINSE_T   = 15;
    localparam int DEF_SPIN_T    = 10;

    // Externally visible phase codes. PAUSED has no code of its own: while
    // paused the phase output keeps showing the suspended phase.
    localparam phase_t PH_OFF   = 3'd0;
    localparam phase_t PH_IDLE  = 3'd1;
    localparam phase_t PH_FILL  = 3'd2;
    localparam phase_t PH_WASH  = 3'd3;
    localparam phase_t PH_DRAIN = 3'd4;
    localparam phase_t PH_RINSE = 3'd5;
    localparam phase_t PH_SPIN  = 3'd6;
    localparam phase_t PH_DONE  = 3'd7;

    // Internal FSM state: low three bits equal the phase code.
    typedef enum logic [3:0] {
        ST_OFF    = {1'b0, PH_OFF},
        ST_IDLE   = {1'b0, PH_IDLE},
        ST_FILL   = {1'b0, PH_FILL},
        ST_WASH   = {1'b0, PH_WASH},
        ST_DRAIN  = {1'b0, PH_DRAIN},
        ST_RINSE  = {1'b0, PH_RINSE},
        ST_SPIN   = {1'b0, PH_SPIN},
        ST_DONE   = {1'b0, PH_DONE},
        ST_PAUSED = 4'd8
    } state_t;

    // Duration of a phase in ticks; zero for non-timed states.
    function automatic time_t phase_len(state_t st, int water_lvl, int fill_step,
                                        int wash_t, int rinse_t, int spin_t);
        time_t len;
        len = '0;
        case (st)
            ST_FILL:  len = time_t'(water_lvl * fill_step);
            ST_WASH:  len = time_t'(wash_t);
            ST_DRAIN: len = time_t'(water_lvl);
            ST_RINSE: len = time_t'(rinse_t);
            ST_SPIN:  len = time_t'(spin_t);
            default:  len = '0;
        endcase
        return len;
    endfunction

    // Whole-program duration: two fills, two drains, wash, rinse, spin.
    function automatic time_t program_total(int water_lvl, int fill_step,
                                           int wash_t, int rinse_t, int spin_t);
        return time_t'(2 * water_lvl * fill_step + 2 * water_lvl
                       + wash_t + rinse_t + spin_t);
    endfunction

    localparam int DEF_TOTAL_T = 2 * DEF_WATER_LVL * DEF_FILL_STEP + 2 * DEF_WATER_LVL
                                 + DEF_WASH_T + DEF_RINSE_T + DEF_SPIN_T;

endpackage
`default_nettype wire

// File: rtl/wash_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wash_sequencer_if                                             |
// | Purpose  : Control pulses in, display-ready status out, for the wash     |
// |            program sequencer.                                            |
// |   master : drives tick_1s / power_pulse / start_pulse, reads status      |
// |   slave  : the sequencer; reads pulses, drives power_light, phase,       |
// |            current_time, total_time, current_water, rest_time, done      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface wash_sequencer_if import wash_pkg::*; ();

    logic   tick_1s;
    logic   power_pulse;
    logic   start_pulse;
    logic   power_light;
    phase_t phase;
    time_t  current_time;
    time_t  total_time;
    water_t current_water;
    time_t  rest_time;
    logic   done;

    modport master (
        output tick_1s, power_pulse, start_pulse,
        input  power_light, phase, current_time, total_time,
               current_water, rest_time, done
    );

    modport slave (
        input  tick_1s, power_pulse, start_pulse,
        output power_light, phase, current_time, total_time,
               current_water, rest_time, done
    );

endinterface
`default_nettype wire

// File: rtl/wash_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wash_sequencer                                                |
// | Purpose  : Power state and wash-program phase FSM, counting program time |
// |            on a 1 Hz tick. All outputs registered.                       |
// | Ports    : clk   - system clock                                          |
// |            rst_n - synchronous active-low reset                          |
// |            bus   - wash_sequencer_if.slave (pulses in, status out)       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module wash_sequencer import wash_pkg::*; #(
    parameter int WATER_LVL = DEF_WATER_LVL,
    parameter int FILL_STEP = DEF_FILL_STEP,
    parameter int WASH_T    = DEF_WASH_T,
    parameter int RINSE_T   = DEF_RINSE_T,
    parameter int SPIN_T    = DEF_SPIN_T
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    wash_sequencer_if.slave   bus
);

    localparam time_t c_total    = program_total(WATER_LVL, FILL_STEP, WASH_T, RINSE_T, SPIN_T);
    localparam time_t c_fill_len = phase_len(ST_FILL, WATER_LVL, FILL_STEP, WASH_T, RINSE_T, SPIN_T);
    localparam time_t c_step_max = time_t'(FILL_STEP - 1);
    localparam time_t c_rest_max = 7'd99;

    state_t r_state;
    state_t r_held;         // phase suspended by a pause
    logic   r_cycle2;       // second (rinse) pass through FILL/DRAIN
    time_t  r_step;         // fill sub-step counter
    logic   r_power_light;
    phase_t r_phase;
    time_t  r_cur;
    time_t  r_total;
    water_t r_water;
    time_t  r_rest;
    logic   r_done;

    state_t w_next_state;
    time_t  w_next_len;
    logic   w_running;
    logic   w_go_off;
    logic   w_load_idle;

    always_comb begin
        w_next_state = ST_DONE;
        case (r_state)
            ST_FILL:  w_next_state = r_cycle2 ? ST_RINSE : ST_WASH;
            ST_WASH:  w_next_state = ST_DRAIN;
            ST_DRAIN: w_next_state = r_cycle2 ? ST_SPIN : ST_FILL;
            ST_RINSE: w_next_state = ST_DRAIN;
            default:  w_next_state = ST_DONE;
        endcase
        w_next_len  = phase_len(w_next_state, WATER_LVL, FILL_STEP, WASH_T, RINSE_T, SPIN_T);
        w_running   = (r_state == ST_FILL) || (r_state == ST_WASH) || (r_state == ST_DRAIN) ||
                      (r_state == ST_RINSE) || (r_state == ST_SPIN);
        // Power toggles OFF<->on; start in DONE re-arms the same program.
        w_go_off    = bus.power_pulse && (r_state != ST_OFF);
        w_load_idle = (bus.power_pulse && (r_state == ST_OFF)) ||
                      (!bus.power_pulse && bus.start_pulse && (r_state == ST_DONE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_go_off) begin
            r_state       <= ST_OFF;
            r_held        <= ST_OFF;
            r_cycle2      <= 1'b0;
            r_step        <= '0;
            r_power_light <= 1'b0;
            r_phase       <= PH_OFF;
            r_cur         <= '0;
            r_total       <= '0;
            r_water       <= '0;
            r_rest        <= '0;
            r_done        <= 1'b0;
        end else if (w_load_idle) begin
            r_state       <= ST_IDLE;
            r_cycle2      <= 1'b0;
            r_step        <= '0;
            r_power_light <= 1'b1;
            r_phase       <= PH_IDLE;
            r_cur         <= c_fill_len;
            r_total       <= c_total;
            r_water       <= '0;
            r_rest        <= '0;
            r_done        <= 1'b0;
        end else if (bus.start_pulse) begin
            // Any tick in the same cycle is intentionally dropped.
            if (r_state == ST_IDLE) begin
                r_state <= ST_FILL;
                r_phase <= PH_FILL;
            end else if (w_running) begin
                r_held  <= r_state;
                r_state <= ST_PAUSED;
                r_rest  <= '0;
            end else if (r_state == ST_PAUSED) begin
                r_state <= r_held;
                r_rest  <= '0;
            end
        end else if (bus.tick_1s) begin
            if (w_running) begin
                r_total <= r_total - 7'd1;
                if (r_state == ST_FILL) begin
                    // The step counter wraps exactly at phase end, so it is
                    // already zero when the next FILL begins.
                    if (r_step == c_step_max) begin
                        r_step  <= '0;
                        r_water <= r_water + 3'd1;
                    end else begin
                        r_step  <= r_step + 7'd1;
                    end
                end else if (r_state == ST_DRAIN) begin
                    r_water <= r_water - 3'd1;
                end
                if (r_cur == 7'd1) begin
                    r_state <= w_next_state;
                    r_phase <= w_next_state[2:0];
                    r_cur   <= w_next_len;
                    if (r_state == ST_DRAIN) begin
                        r_cycle2 <= 1'b1;
                    end
                    if (w_next_state == ST_DONE) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_cur <= r_cur - 7'd1;
                end
            end else if (r_state == ST_PAUSED) begin
                if (r_rest != c_rest_max) begin
                    r_rest <= r_rest + 7'd1;
                end
            end
        end
    end

    assign bus.power_light   = r_power_light;
    assign bus.phase         = r_phase;
    assign bus.current_time  = r_cur;
    assign bus.total_time    = r_total;
    assign bus.current_water = r_water;
    assign bus.rest_time     = r_rest;
    assign bus.done          = r_done;

endmodule
`default_nettype wire
